// File: rtl/mux_en_tx_if.sv
// Handshake and CDC bus bundle for the mux-enable transmitter.
// The slave modport is the transmitter; the master modport is its environment.
interface mux_en_tx_if #(
  parameter int unsigned width = 8
);
  logic [width-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic [width-1:0] tx_data;
  logic             tx_req;
  logic             ack_in;
  logic             done;
  logic             err_timeout;
  logic             err_spurious;
  logic             clr_err;

  modport slave (
    input  data_in, valid_in, ack_in, clr_err,
    output ready_out, tx_data, tx_req, done, err_timeout, err_spurious
  );

  modport master (
    output data_in, valid_in, ack_in, clr_err,
    input  ready_out, tx_data, tx_req, done, err_timeout, err_spurious
  );
endinterface

// File: rtl/mux_en_tx.sv
// Source-side transmitter for the mux-enable CDC scheme: holds a word on tx_data,
// toggles tx_req once per transfer and waits for the matching synchronized ack toggle.
module mux_en_tx #(
  parameter int unsigned width       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 0
) (
  input logic        clk,
  input logic        rst_n,
  mux_en_tx_if.slave bus
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitAck} state_e;

  state_e                 state_q;
  logic [width-1:0]       tx_data_q;
  logic                   tx_req_q;
  logic                   done_q;
  logic                   err_timeout_q;
  logic                   err_spurious_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_prev_q;
  logic [TimerW-1:0]      timer_q;

  logic ack_s;
  logic ack_edge;
  logic ack_ok;
  logic spurious;

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign ack_edge = ack_s ^ ack_prev_q;
  assign ack_ok   = ack_edge && (ack_s == tx_req_q);
  // Any ack toggle outside WAIT_ACK, or one that does not match the request level.
  assign spurious = ack_edge && ((state_q != StWaitAck) || (ack_s != tx_req_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      tx_data_q      <= '0;
      tx_req_q       <= 1'b0;
      done_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
      sync_q         <= '0;
      ack_prev_q     <= 1'b0;
      timer_q        <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.ack_in};
      ack_prev_q <= ack_s;
      done_q     <= 1'b0;

      if (bus.clr_err) begin
        err_timeout_q  <= 1'b0;
        err_spurious_q <= 1'b0;
      end
      if (spurious) begin
        err_spurious_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.valid_in) begin
            tx_data_q <= bus.data_in;
            state_q   <= StLaunch;
          end
        end
        StLaunch: begin
          tx_req_q <= ~tx_req_q;
          timer_q  <= '0;
          state_q  <= StWaitAck;
        end
        StWaitAck: begin
          if (ack_ok) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            if (timer_q != {TimerW{1'b1}}) begin
              timer_q <= timer_q + 1'b1;
            end
            if ((TIMEOUT != 0) && (timer_q == TimerLast)) begin
              err_timeout_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready_out    = (state_q == StIdle);
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_req       = tx_req_q;
  assign bus.done         = done_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.err_spurious = err_spurious_q;

endmodule

// File: tb/tb_mux_en_tx.sv
// Directed bench for mux_en_tx: loopback instance (no timeout) and a
// manually acked instance with a 16-cycle timeout.
module tb_mux_en_tx;

  logic clk   = 1'b0;
  logic aclk  = 1'b0;
  logic rst_n = 1'b1;

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int ack_mode = 0;

  initial forever #5 clk = ~clk;
  initial forever #3.5 aclk = ~aclk;

  mux_en_tx_if #(.width(8)) if0 ();
  mux_en_tx_if #(.width(8)) if1 ();

  mux_en_tx #(.width(8), .SYNC_STAGES(2), .TIMEOUT(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  mux_en_tx #(.width(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (if0.done) done_cnt <= done_cnt + 1;

  // Destination model for dut0: immediate loopback, or a random delay on a foreign clock.
  initial begin
    if0.ack_in = 1'b0;
    forever begin
      @(if0.tx_req);
      if (ack_mode == 0) begin
        if0.ack_in = if0.tx_req;
      end else begin
        repeat ($urandom_range(40, 3)) @(posedge aclk);
        if0.ack_in = if0.tx_req;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] words [3];
  logic       reqs  [3];
  int         acc   [3];
  int         n;
  int         d0;
  logic       held;
  logic [7:0] w;

  initial begin
    words = '{8'h01, 8'h02, 8'h03};
    reqs  = '{1'b1, 1'b0, 1'b1};
    if0.data_in = '0; if0.valid_in = 1'b0; if0.clr_err = 1'b0;
    if1.data_in = '0; if1.valid_in = 1'b0; if1.clr_err = 1'b0; if1.ack_in = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ready", if0.ready_out, 1);
    check_eq("rst_data", if0.tx_data, 0);
    check_eq("rst_req", if0.tx_req, 0);
    check_eq("rst_done", if0.done, 0);
    check_eq("rst_errs", {if1.err_timeout, if1.err_spurious}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single loopback transfer
    if0.data_in = 8'hA5; if0.valid_in = 1'b1;
    tick();
    if0.valid_in = 1'b0;
    check_eq("lb_data", if0.tx_data, 8'hA5);
    check_eq("lb_busy", if0.ready_out, 0);
    check_eq("lb_req0", if0.tx_req, 0);
    tick();
    check_eq("lb_req1", if0.tx_req, 1);
    tick();
    tick();
    check_eq("lb_done_early", if0.done, 0);
    tick();
    check_eq("lb_done", if0.done, 1);
    check_eq("lb_ready", if0.ready_out, 1);
    tick();
    check_eq("lb_done_pulse", if0.done, 0);
    check_eq("lb_errs", {if0.err_timeout, if0.err_spurious}, 0);

    // Back-to-back words after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!if0.ready_out && n < 20) begin tick(); n++; end
      if0.data_in = words[k]; if0.valid_in = 1'b1;
      tick();
      acc[k] = cyc;
      check_eq("b2b_data", if0.tx_data, words[k]);
      if0.data_in = 8'hFF;
      tick();
      check_eq("b2b_req", if0.tx_req, reqs[k]);
      held = 1'b1;
      n = 0;
      while (!if0.ready_out && n < 20) begin
        if (if0.tx_data != words[k]) held = 1'b0;
        tick();
        n++;
      end
      check_eq("b2b_held", held & (if0.tx_data == words[k]), 1);
      check_eq("b2b_ready", if0.ready_out, 1);
      if (k > 0) check_eq("b2b_gap", acc[k] - acc[k-1], 5);
    end
    if0.valid_in = 1'b0;

    // Timeout on dut1 with ack held low
    if1.data_in = 8'h5A; if1.valid_in = 1'b1;
    tick();
    if1.valid_in = 1'b0;
    tick();
    repeat (15) tick();
    check_eq("to_early", if1.err_timeout, 0);
    tick();
    check_eq("to_set", if1.err_timeout, 1);
    check_eq("to_busy", if1.ready_out, 0);
    check_eq("to_held", if1.tx_data, 8'h5A);
    if1.ack_in = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!if1.done && n < 10);
    check_eq("to_done", if1.done, 1);
    check_eq("to_sticky", if1.err_timeout, 1);
    tick();
    if1.clr_err = 1'b1;
    tick();
    if1.clr_err = 1'b0;
    check_eq("to_clr", if1.err_timeout, 0);

    // Spurious ack while idle, clear, and set-wins-over-clear
    if1.ack_in = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!if1.err_spurious && n < 6);
    check_eq("sp_set", if1.err_spurious, 1);
    check_eq("sp_idle", if1.ready_out, 1);
    check_eq("sp_req", if1.tx_req, 1);
    if1.clr_err = 1'b1;
    tick();
    if1.clr_err = 1'b0;
    check_eq("sp_clr", if1.err_spurious, 0);
    if1.ack_in = 1'b1;
    tick();
    tick();
    if1.clr_err = 1'b1;
    tick();
    check_eq("sp_set_wins", if1.err_spurious, 1);
    tick();
    check_eq("sp_clr2", if1.err_spurious, 0);
    if1.clr_err = 1'b0;

    // Reset during WAIT_ACK, after the timeout flag has set
    if1.data_in = 8'h77; if1.valid_in = 1'b1;
    tick();
    if1.valid_in = 1'b0;
    repeat (18) tick();
    check_eq("rm_pre_to", if1.err_timeout, 1);
    rst_n = 1'b0;
    if1.ack_in = 1'b0;
    #1;
    check_eq("rm_req", if1.tx_req, 0);
    check_eq("rm_data", if1.tx_data, 0);
    check_eq("rm_done", if1.done, 0);
    check_eq("rm_errs", {if1.err_timeout, if1.err_spurious}, 0);
    check_eq("rm_ready", if1.ready_out, 1);
    tick();
    rst_n = 1'b1;
    tick();
    if1.data_in = 8'h3C; if1.valid_in = 1'b1;
    tick();
    if1.valid_in = 1'b0;
    tick();
    check_eq("rm_req1", if1.tx_req, 1);
    if1.ack_in = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!if1.done && n < 10);
    check_eq("rm_fresh_done", if1.done, 1);
    check_eq("rm_fresh_data", if1.tx_data, 8'h3C);
    check_eq("rm_fresh_errs", {if1.err_timeout, if1.err_spurious}, 0);

    // Random ack delay on an unrelated clock
    ack_mode = 1;
    d0 = done_cnt;
    for (int k = 0; k < 1000; k++) begin
      w = 8'($urandom);
      n = 0;
      while (!if0.ready_out && n < 100) begin tick(); n++; end
      if0.data_in = w; if0.valid_in = 1'b1;
      tick();
      if0.valid_in = 1'b0;
      check_eq("rnd_data", if0.tx_data, w);
      n = 0;
      do begin tick(); n++; end while (!if0.done && n < 100);
      check_eq("rnd_done", if0.done, 1);
    end
    tick();
    check_eq("rnd_done_cnt", done_cnt - d0, 1000);
    check_eq("rnd_errs", {if0.err_timeout, if0.err_spurious}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
